shiftreg_tx: RTL and testbench
==============================

# shiftreg_tx

Parallel-to-serial transmitter that produces the bit stream our serial-in shift register consumes. It accepts a WIDTH-bit parallel word on a ready/request handshake and shifts it out MSB-first on a single serial line, one bit per clock. It marks the valid bits with a framing strobe and signals completion with a one-cycle done pulse. It sits on the sending side of the serial link and drives the receiver's `Incoming`/`ctrl` pair directly via `Outgoing`/`frame`.

## Interface
- `WIDTH`, default 4: data word width in bits; legal range 2–16.
- `clk`  in  1: clock; all state changes on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `ctrl`  in  1: load request; the word is accepted on a rising edge where `ctrl`=1 and `ready`=1.
- `num`  in  WIDTH: parallel word, sampled only on the accepting edge.
- `ready`  out  1: high only in IDLE; the block can accept a word.
- `Outgoing`  out  1: serial data, MSB first; 0 when not framing.
- `frame`  out  1: high exactly while `Outgoing` carries a data or parity bit.
- `done`  out  1: one-cycle pulse after the last bit.

## Operation
- All outputs are registered. States: IDLE, SHIFT, PARITY (only with the macro), DONE.
- Reset (async, any time, including mid-frame) forces IDLE immediately:
  - `ready`=1, `Outgoing`=0, `frame`=0, `done`=0.
  - Shift register and bit counter are cleared; any word in flight is discarded and no done pulse is issued.
- IDLE:
  - On `ctrl`=1, capture `num` into the shift register, set bit counter to 0 and go to SHIFT.
  - `Outgoing` is loaded with `num[WIDTH-1]` and `frame` goes to 1 on that same edge; `ready` drops to 0.
  - `ctrl`=0 holds IDLE.
- SHIFT:
  - Each edge shifts left by one and presents the next bit; the counter increments.
  - After the edge that would present bit index WIDTH (all WIDTH bits sent), go to PARITY if compiled in, otherwise DONE.
  - `ctrl` and `num` are ignored.
- PARITY: `Outgoing` = even-parity bit (XOR of the captured word), so that data plus parity contains an even number of ones. `frame`=1. Lasts one cycle, then DONE.
- DONE: `done`=1, `frame`=0, `Outgoing`=0, `ready`=0. Lasts one cycle, then IDLE.
- Counter width: $clog2(WIDTH+1). There is no wrap-around, because the counter is cleared on every load.

## Timing
- Let E0 be the accepting edge.
- Data bit i (i=0 being the MSB) is valid during the cycle following edge E(i).
- `frame` is high for WIDTH cycles (WIDTH+1 with parity), contiguous.
- `done` is high during the cycle after edge E(WIDTH) (E(WIDTH+1) with parity).
- `ready` returns to 1 one edge later.
- Earliest next accept: E(WIDTH+2) without parity, E(WIDTH+3) with parity. Frame-to-frame period: WIDTH+2 / WIDTH+3 cycles.
- `ctrl` held high continuously yields back-to-back frames at exactly that period.
- Deasserting `ctrl` after E0 has no effect on the frame in progress.

## Configuration
- `SHIFTREG_TX_PARITY_EN`:
  - Defined: PARITY state present; one even-parity bit follows the data with `frame` still high; all latencies grow by one cycle.
  - Undefined: PARITY state and parity logic are absent; DONE follows the last data bit directly.

## Test plan
- Reset, then hold idle: `ready`=1, `Outgoing`=0, `frame`=0, `done`=0 for 3 cycles.
- `num`=4'b1100, one-cycle `ctrl` pulse (no parity):
  - `Outgoing` = 1,1,0,0 on the 4 cycles after E0, with `frame`=1 on exactly those cycles.
  - `done`=1 on the 5th cycle; `ready`=1 on the 6th.
- Same stimulus with `SHIFTREG_TX_PARITY_EN`:
  - Bits 1,1,0,0 followed by parity 0, `frame` high for 5 cycles.
  - `num`=4'b1011 gives parity bit 1.
- `ctrl` held high with `num` toggling every cycle:
  - Only the values present on accepting edges are transmitted.
  - Frames are back-to-back at a 6-cycle period (7 with parity).
- Assert `rst` asynchronously mid-edge during the 2nd data bit:
  - Outputs return to reset values immediately, with no `done` pulse.
  - After release, a new word 4'b0101 transmits cleanly as 0,1,0,1.
- Loopback into the serial-in shift register, driven by `Outgoing`/`frame`: after one frame of 4'b1010, the receiver's parallel output equals 4'b1010.

Source files
------------

// File: rtl/shiftreg_tx_if.sv
// Handshake/serial bundle for shiftreg_tx: parallel load request/word in,
// serial data with framing strobe and done pulse out.
interface shiftreg_tx_if #(
  parameter int unsigned WIDTH = 4
) ();
  logic             ctrl;
  logic [WIDTH-1:0] num;
  logic             ready;
  logic             Outgoing;
  logic             frame;
  logic             done;

  modport master (
    output ctrl, num,
    input  ready, Outgoing, frame, done
  );

  modport slave (
    input  ctrl, num,
    output ready, Outgoing, frame, done
  );
endinterface

// File: rtl/shiftreg_tx.sv
// Parallel-to-serial transmitter, MSB first, with framing strobe and done pulse.
// Define SHIFTREG_TX_PARITY_EN to append one even-parity bit after the data.
module shiftreg_tx #(
  parameter int unsigned WIDTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  shiftreg_tx_if.slave   bus
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

`ifdef SHIFTREG_TX_PARITY_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_PARITY = 2'd2, S_DONE = 2'd3} state_e;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_DONE = 2'd3} state_e;
`endif

  state_e           state_q, state_d;
  // MSB goes straight to the output on load, so only the remaining bits are held.
  logic [WIDTH-2:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ready_q, ready_d;
  logic             out_q, out_d;
  logic             frame_q, frame_d;
  logic             done_q, done_d;
`ifdef SHIFTREG_TX_PARITY_EN
  logic             parity_q, parity_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      sr_q     <= '0;
      cnt_q    <= '0;
      ready_q  <= 1'b1;
      out_q    <= 1'b0;
      frame_q  <= 1'b0;
      done_q   <= 1'b0;
`ifdef SHIFTREG_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      out_q    <= out_d;
      frame_q  <= frame_d;
      done_q   <= done_d;
`ifdef SHIFTREG_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    ready_d  = 1'b0;
    out_d    = 1'b0;
    frame_d  = 1'b0;
    done_d   = 1'b0;
`ifdef SHIFTREG_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      S_IDLE: begin
        ready_d = 1'b1;
        if (bus.ctrl) begin
          sr_d     = bus.num[WIDTH-2:0];
          cnt_d    = '0;
          out_d    = bus.num[WIDTH-1];
          frame_d  = 1'b1;
          ready_d  = 1'b0;
          state_d  = S_SHIFT;
`ifdef SHIFTREG_TX_PARITY_EN
          parity_d = ^bus.num;
`endif
        end
      end
      S_SHIFT: begin
        sr_d  = sr_q << 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
`ifdef SHIFTREG_TX_PARITY_EN
          state_d = S_PARITY;
          out_d   = parity_q;
          frame_d = 1'b1;
`else
          state_d = S_DONE;
          done_d  = 1'b1;
`endif
        end else begin
          out_d   = sr_q[WIDTH-2];
          frame_d = 1'b1;
        end
      end
`ifdef SHIFTREG_TX_PARITY_EN
      S_PARITY: begin
        state_d = S_DONE;
        done_d  = 1'b1;
      end
`endif
      S_DONE: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  assign bus.ready    = ready_q;
  assign bus.Outgoing = out_q;
  assign bus.frame    = frame_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_shiftreg_tx.sv
// Directed bench for shiftreg_tx: vector table of words with hand-computed
// serial streams, plus back-to-back, mid-frame reset and loopback sequences.
module tb_shiftreg_tx;

  localparam int unsigned W = 4;
`ifdef SHIFTREG_TX_PARITY_EN
  localparam int unsigned PAR = 1;
`else
  localparam int unsigned PAR = 0;
`endif
  localparam int unsigned FL = W + PAR;
  localparam int unsigned P  = W + 2 + PAR;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  shiftreg_tx_if #(.WIDTH(W)) bus ();
  shiftreg_tx #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int errors = 0;
  int checks = 0;

  // Serial-in receiver: takes the first W framed bits of each frame.
  logic [W-1:0] rx_q;
  int           rx_n;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_q <= '0;
      rx_n <= 0;
    end else if (bus.frame) begin
      if (rx_n < int'(W)) begin
        rx_q <= {rx_q[W-2:0], bus.Outgoing};
        rx_n <= rx_n + 1;
      end
    end else begin
      rx_n <= 0;
    end
  end

  // seq[4:1] = data bits MSB first, seq[0] = even-parity bit
  typedef struct {
    logic [3:0] num;
    logic [4:0] seq;
    string      name;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string name);
    chk({name, " ready"}, 32'(bus.ready), 32'd1);
    chk({name, " out"},   32'(bus.Outgoing), 32'd0);
    chk({name, " frame"}, 32'(bus.frame), 32'd0);
    chk({name, " done"},  32'(bus.done), 32'd0);
  endtask

  task automatic send(input logic [3:0] n, input logic [4:0] seq, input string name);
    bus.ctrl = 1'b1;
    bus.num  = n;
    step();
    bus.ctrl = 1'b0;
    bus.num  = ~n;
    for (int i = 0; i < int'(FL); i++) begin
      chk({name, " bit"},   32'(bus.Outgoing), 32'(seq[4-i]));
      chk({name, " frame"}, 32'(bus.frame), 32'd1);
      chk({name, " ready"}, 32'(bus.ready), 32'd0);
      chk({name, " done"},  32'(bus.done), 32'd0);
      step();
    end
    chk({name, " done pulse"}, 32'(bus.done), 32'd1);
    chk({name, " frame end"},  32'(bus.frame), 32'd0);
    chk({name, " out end"},    32'(bus.Outgoing), 32'd0);
    chk({name, " ready low"},  32'(bus.ready), 32'd0);
    step();
    chk({name, " ready back"}, 32'(bus.ready), 32'd1);
    chk({name, " done clear"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    logic [4:0] sa, sb, s;
    int pos;

    vecs[0] = '{4'b1100, 5'b11000, "v1100"};
    vecs[1] = '{4'b1011, 5'b10111, "v1011"};
    vecs[2] = '{4'b0101, 5'b01010, "v0101"};
    vecs[3] = '{4'b1111, 5'b11110, "v1111"};
    vecs[4] = '{4'b0001, 5'b00011, "v0001"};
    vecs[5] = '{4'b1000, 5'b10001, "v1000"};

    bus.ctrl = 1'b0;
    bus.num  = '0;
    #1 rst = 1'b1;
    #1 chk_idle("reset");
    #10 rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk_idle("idle");
    end

    for (int k = 0; k < 6; k++) send(vecs[k].num, vecs[k].seq, vecs[k].name);

    // ctrl held high; num only matters on accepting edges
    sa = vecs[0].seq;
    sb = vecs[1].seq;
    bus.ctrl = 1'b1;
    bus.num  = vecs[0].num;
    step();
    for (int c = 0; c < int'(2 * P); c++) begin
      pos = c % int'(P);
      s   = (c < int'(P)) ? sa : sb;
      if (pos < int'(FL)) begin
        chk("b2b bit",   32'(bus.Outgoing), 32'(s[4-pos]));
        chk("b2b frame", 32'(bus.frame), 32'd1);
        chk("b2b ready", 32'(bus.ready), 32'd0);
      end else if (pos == int'(FL)) begin
        chk("b2b done",  32'(bus.done), 32'd1);
        chk("b2b frame", 32'(bus.frame), 32'd0);
      end else begin
        chk("b2b ready", 32'(bus.ready), 32'd1);
        chk("b2b done",  32'(bus.done), 32'd0);
      end
      bus.num = (c == int'(P) - 1) ? vecs[1].num : 4'(c * 7 + 1);
      if (c == int'(2 * P) - 1) bus.ctrl = 1'b0;
      step();
    end
    chk_idle("b2b after");

    // async reset while the second data bit is on the line
    bus.ctrl = 1'b1;
    bus.num  = 4'b1100;
    step();
    bus.ctrl = 1'b0;
    step();
    chk("pre-rst bit1", 32'(bus.Outgoing), 32'd1);
    #3 rst = 1'b1;
    #1 chk_idle("async rst");
    step();
    chk_idle("rst held");
    #2 rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      chk_idle("post rst");
    end
    send(4'b0101, 5'b01010, "after rst");

    send(4'b1010, 5'b10100, "loopback");
    chk("loopback rx", 32'(rx_q), 32'(4'b1010));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
